// File: rtl/periodic_irq_gen_if.sv
// periodic_irq_gen_if: channel control, period write, ack and interrupt signals of periodic_irq_gen
interface periodic_irq_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 27,
  parameter int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] irq_en;
  logic period_wr;
  logic [SEL_W-1:0] period_sel;
  logic [CNT_W-1:0] period_data;
  logic interrupt_ack;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] irq_pending;
  logic [SEL_W-1:0] irq_src;
  logic interrupt;
  modport master (
    output ch_en, irq_en, period_wr, period_sel, period_data, interrupt_ack,
    input tick, irq_pending, irq_src, interrupt
  );
  modport slave (
    input ch_en, irq_en, period_wr, period_sel, period_data, interrupt_ack,
    output tick, irq_pending, irq_src, interrupt
  );
endinterface

// File: rtl/periodic_irq_gen.sv
// periodic_irq_gen: per-channel programmable periodic tick plus latched, acked PicoBlaze interrupt
//   clk, reset : clock, synchronous active-high reset
//   bus        : ch_en/irq_en enables, period_wr/period_sel/period_data period writes,
//                interrupt_ack in; tick, irq_pending, irq_src, interrupt out
module periodic_irq_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 27,
  parameter int PULSE_W = 3,
  parameter int DEFAULT_PERIOD = 100000000
) (
  input logic clk,
  input logic reset,
  periodic_irq_gen_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = $clog2(PULSE_W + 1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(PULSE_W + 1);
  logic [NUM_CH-1:0] tc, tick, pend, ack_mask;
  logic [SEL_W-1:0] src, lowest;
  logic intr;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] period, cnt, pe;
    logic [PW-1:0] rem;
    logic wr;
    // out-of-range selects match no channel, so such writes are dropped
    assign wr = bus.period_wr && bus.period_sel == SEL_W'(i);
    // clamp keeps a full low cycle between consecutive pulses
    assign pe = (period < MIN_P) ? MIN_P : period;
    assign tc[i] = bus.ch_en[i] && cnt == pe - 1'b1;
    assign tick[i] = bus.ch_en[i] && rem != '0;
    always_ff @(posedge clk) begin
      if (reset) begin
        period <= CNT_W'(DEFAULT_PERIOD);
        cnt <= '0;
        rem <= '0;
      end else begin
        if (wr) period <= bus.period_data;
        cnt <= (wr || !bus.ch_en[i] || tc[i]) ? '0 : cnt + 1'b1;
        rem <= (wr || !bus.ch_en[i]) ? '0 : tc[i] ? PW'(PULSE_W) : rem - PW'(rem != '0);
      end
    end
  end
  always_comb begin
    lowest = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) if (pend[k]) lowest = SEL_W'(k);
  end
  // ack targets the registered irq_src; a same-cycle set on that channel wins
  assign ack_mask = bus.interrupt_ack ? NUM_CH'(1) << src : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      src <= '0;
      intr <= 1'b0;
    end else begin
      pend <= (pend & ~ack_mask) | (tc & bus.irq_en);
      src <= lowest;
      intr <= |pend;
    end
  end
  assign bus.tick = tick;
  assign bus.irq_pending = pend;
  assign bus.irq_src = src;
  assign bus.interrupt = intr;
endmodule

// File: tb/tb_periodic_irq_gen.sv
// tb_periodic_irq_gen: vector table, directed corner cases and random stimulus against a timing model
module tb_periodic_irq_gen;
  localparam int N = 4, CW = 8, PW = 3, DEF = 12, SW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  periodic_irq_gen_if #(.NUM_CH(N), .CNT_W(CW)) bus ();
  periodic_irq_gen #(.NUM_CH(N), .CNT_W(CW), .PULSE_W(PW), .DEFAULT_PERIOD(DEF)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  periodic_irq_gen_if #(.NUM_CH(3), .CNT_W(CW)) b3 ();
  periodic_irq_gen #(.NUM_CH(3), .CNT_W(CW), .PULSE_W(PW), .DEFAULT_PERIOD(6)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave));
  typedef struct {
    logic [3:0] en, ie;
    logic wr;
    logic [1:0] sel;
    logic [7:0] data;
    logic ack;
    logic [3:0] tk, pd;
    logic [1:0] sr;
    logic it;
  } vec_t;
  vec_t tbl[$];
  int checks = 0, fails = 0;
  int per[N], start[N], cyc, m_src;
  logic [N-1:0] restart, m_pend, m_tick, m_tc;
  logic m_int;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [3:0] en, ie, input logic wr, input logic [1:0] sel,
                     input logic [7:0] data, input logic ack, input logic [3:0] tk, pd,
                     input logic [1:0] sr, input logic it);
    tbl.push_back('{en, ie, wr, sel, data, ack, tk, pd, sr, it});
  endtask
  function automatic int pe_of(input int i);
    return per[i] > PW ? per[i] : PW + 1;
  endfunction
  function automatic int low_idx(input logic [N-1:0] v);
    int k = 0;
    while (k < N && !v[k]) k++;
    return k < N ? k : 0;
  endfunction
  // each enabled run counts cycles from its start; ticks and TCs fall out of modular arithmetic
  task automatic check_model(input string tag);
    int e, p;
    @(negedge clk);
    m_tick = '0;
    m_tc = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.ch_en[i]) begin
        if (restart[i]) begin
          start[i] = cyc;
          restart[i] = 1'b0;
        end
        e = cyc - start[i];
        p = pe_of(i);
        m_tick[i] = e >= p && e % p < PW;
        m_tc[i] = e % p == p - 1;
      end
    end
    chk({tag, " tick"}, 32'(bus.tick), 32'(m_tick));
    chk({tag, " pending"}, 32'(bus.irq_pending), 32'(m_pend));
    chk({tag, " irq_src"}, 32'(bus.irq_src), 32'(m_src));
    chk({tag, " interrupt"}, 32'(bus.interrupt), 32'(m_int));
  endtask
  task automatic advance();
    logic [N-1:0] ack_m;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < N; i++) per[i] = DEF;
      restart = '1;
      m_pend = '0;
      m_src = 0;
      m_int = 1'b0;
    end else begin
      ack_m = bus.interrupt_ack ? N'(1) << m_src : '0;
      m_int = m_pend != '0;
      m_src = low_idx(m_pend);
      m_pend = (m_pend & ~ack_m) | (m_tc & bus.irq_en);
      if (bus.period_wr && int'(bus.period_sel) < N) begin
        per[bus.period_sel] = int'(bus.period_data);
        restart[bus.period_sel] = 1'b1;
      end
      for (int i = 0; i < N; i++) if (!bus.ch_en[i]) restart[i] = 1'b1;
    end
    cyc++;
    #1;
  endtask
  initial begin
    int n;
    logic found;
    add(0, 0, 1, 0, 5, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 2; k <= 5; k++) add(3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    add(3, 1, 0, 0, 0, 0, 3, 1, 0, 1);
    add(3, 1, 0, 0, 0, 0, 1, 1, 0, 1);
    add(3, 1, 0, 0, 0, 0, 2, 1, 0, 1);
    add(3, 1, 0, 0, 0, 1, 2, 1, 0, 1);
    add(3, 1, 0, 0, 0, 0, 3, 1, 0, 1);
    add(3, 1, 0, 0, 0, 1, 1, 1, 0, 1);
    add(3, 1, 0, 0, 0, 0, 3, 0, 0, 1);
    add(3, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    add(3, 3, 0, 0, 0, 0, 3, 1, 0, 1);
    add(3, 3, 0, 0, 0, 0, 3, 1, 0, 1);
    add(3, 3, 0, 0, 0, 0, 2, 1, 0, 1);
    add(3, 3, 0, 0, 0, 0, 0, 1, 0, 1);
    add(3, 3, 0, 0, 0, 1, 3, 3, 0, 1);
    add(3, 3, 0, 0, 0, 0, 3, 2, 0, 1);
    add(3, 3, 0, 0, 0, 1, 3, 2, 1, 1);
    add(3, 3, 0, 0, 0, 0, 0, 0, 1, 1);
    {bus.ch_en, bus.irq_en, bus.period_wr, bus.period_sel, bus.period_data, bus.interrupt_ack} = '0;
    {b3.ch_en, b3.irq_en, b3.period_wr, b3.period_sel, b3.period_data, b3.interrupt_ack} = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) per[i] = DEF;
    restart = '1;
    m_pend = '0;
    m_src = 0;
    m_int = 1'b0;
    cyc = 0;
    foreach (tbl[k]) begin
      bus.ch_en = tbl[k].en;
      bus.irq_en = tbl[k].ie;
      bus.period_wr = tbl[k].wr;
      bus.period_sel = tbl[k].sel;
      bus.period_data = tbl[k].data;
      bus.interrupt_ack = tbl[k].ack;
      check_model("tbl");
      chk($sformatf("row%0d tick", k), 32'(bus.tick), 32'(tbl[k].tk));
      chk($sformatf("row%0d pending", k), 32'(bus.irq_pending), 32'(tbl[k].pd));
      chk($sformatf("row%0d irq_src", k), 32'(bus.irq_src), 32'(tbl[k].sr));
      chk($sformatf("row%0d interrupt", k), 32'(bus.interrupt), 32'(tbl[k].it));
      advance();
    end
    bus.irq_en = '0;
    bus.interrupt_ack = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      check_model("t5 wait");
      found = bus.tick[0];
      advance();
    end
    chk("t5 tick seen", 32'(found), 1);
    bus.period_wr = 1'b1;
    bus.period_sel = 0;
    bus.period_data = 7;
    check_model("t5 write");
    chk("t5 mid tick", 32'(bus.tick[0]), 1);
    advance();
    bus.period_wr = 1'b0;
    check_model("t5 abort");
    chk("t5 aborted", 32'(bus.tick[0]), 0);
    advance();
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      check_model("t5 count");
      n++;
      found = bus.tick[0];
      advance();
    end
    chk("t5 new period delay", n, 7);
    bus.ch_en = '1;
    bus.irq_en = '1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      check_model("t6 wait");
      found = bus.irq_pending == '1 && bus.tick != '0;
      advance();
    end
    chk("t6 all pending", 32'(found), 1);
    reset = 1'b1;
    check_model("t6 reset");
    advance();
    reset = 1'b0;
    check_model("t6 after");
    chk("t6 tick zero", 32'(bus.tick), 0);
    chk("t6 pending zero", 32'(bus.irq_pending), 0);
    chk("t6 src zero", 32'(bus.irq_src), 0);
    chk("t6 interrupt zero", 32'(bus.interrupt), 0);
    advance();
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      check_model("t6 count");
      n++;
      found = bus.tick[0];
      advance();
    end
    chk("t6 default period", n, DEF);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) bus.ch_en[i] = ~bus.ch_en[i];
      if ($urandom_range(0, 31) == 0) bus.irq_en = N'($urandom);
      bus.period_wr = $urandom_range(0, 19) == 0;
      bus.period_sel = SW'($urandom);
      bus.period_data = CW'($urandom_range(0, 20));
      bus.interrupt_ack = $urandom_range(0, 3) == 0;
      reset = $urandom_range(0, 299) == 0;
      check_model("rnd");
      advance();
    end
    reset = 1'b0;
    bus.ch_en = '0;
    b3.ch_en = 3'b111;
    for (int e = 0; e < 14; e++) begin
      b3.period_wr = e == 7;
      b3.period_sel = 2'd3;
      b3.period_data = 1;
      @(negedge clk);
      chk($sformatf("sel_oob tick e%0d", e), 32'(b3.tick), (e >= 6 && e % 6 < PW) ? 7 : 0);
      chk($sformatf("sel_oob pending e%0d", e), 32'(b3.irq_pending), 0);
      @(posedge clk);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
